// File: rtl/sll_seq.sv
// Iterative shift-left unit: one bit position per clock with a selectable LSB fill bit.
// Optional sticky overflow output enabled by defining SLL_SEQ_OVF_EN.
module sll_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] data_in_i,
  input  logic [4:0]  shamt_i,
  input  logic        lsb_i,
`ifdef SLL_SEQ_OVF_EN
  output logic        overflow_o,
`endif
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sreg_q, sreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        lsb_q, lsb_d;
`ifdef SLL_SEQ_OVF_EN
  logic        ovf_q, ovf_d;
`endif

  // State, shift register, counter and latched fill bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
`ifdef SLL_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
`ifdef SLL_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    lsb_d   = lsb_q;
`ifdef SLL_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sreg_d  = data_in_i;
          cnt_d   = shamt_i;
          lsb_d   = lsb_i;
`ifdef SLL_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = (shamt_i != 5'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[30:0], lsb_q};
        cnt_d  = cnt_q - 5'd1;
`ifdef SLL_SEQ_OVF_EN
        if (sreg_q[31]) ovf_d = 1'b1;
`endif
        if (cnt_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state
  always_comb begin
    ready_o  = (state_q == IDLE);
    done_o   = (state_q == DONE);
    result_o = sreg_q;
`ifdef SLL_SEQ_OVF_EN
    overflow_o = ovf_q;
`endif
  end

endmodule

// File: tb/tb_sll_seq.sv
// Randomized self-checking bench for sll_seq against an arithmetic reference.
// Also covers the directed corner cases: zero/max shift, busy start, reset.
module tb_sll_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        lsb;
  logic        ready;
  logic        done;
  logic [31:0] result;
`ifdef SLL_SEQ_OVF_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  sll_seq dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .data_in_i  (data_in),
    .shamt_i    (shamt),
    .lsb_i      (lsb),
`ifdef SLL_SEQ_OVF_EN
    .overflow_o (overflow),
`endif
    .ready_o    (ready),
    .done_o     (done),
    .result_o   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] d,
                                          input int s,
                                          input logic l);
    logic [63:0] x;
    x = {32'd0, d} << s;
    if (l) x = x | ((64'd1 << s) - 64'd1);
    return x[31:0];
  endfunction

  function automatic logic ref_ovf(input logic [31:0] d,
                                   input int s);
    logic [63:0] x;
    x = {32'd0, d} << s;
    return (x[63:32] != 32'd0);
  endfunction

  // Caller is at a negedge with ready expected high. Returns at the
  // negedge after done, so a following call is a back-to-back accept.
  task automatic do_op(input string tag,
                       input logic [31:0] d,
                       input logic [4:0] s,
                       input logic l,
                       input bit poke);
    int lat;
    int ndone;
    bit seen;
    logic [31:0] exp_r;
    exp_r = ref_res(d, int'(s), l);
    check({tag, "_rdy"}, 32'(ready), 32'd1);
    data_in = d;
    shamt   = s;
    lsb     = l;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = $urandom;
    shamt   = 5'($urandom);
    lsb     = 1'($urandom);
    lat   = 0;
    ndone = 0;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1;
        lat  = i;
        break;
      end
      if (poke && (i % 3 == 1)) begin
        start   = 1'b1;
        data_in = 32'h1;
        shamt   = 5'd1;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_lat"}, lat, 32'(s));
      check({tag, "_res"}, result, exp_r);
      check({tag, "_rdy_d"}, 32'(ready), 32'd0);
`ifdef SLL_SEQ_OVF_EN
      check({tag, "_ovf"}, 32'(overflow), 32'(ref_ovf(d, int'(s))));
`endif
      @(negedge clk);
      check({tag, "_pulse"}, 32'(done), 32'd0);
      check({tag, "_rdy_n"}, 32'(ready), 32'd1);
      check({tag, "_hold"}, result, exp_r);
    end
    ndone = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [4:0]  rs;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    lsb     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
`ifdef SLL_SEQ_OVF_EN
    check("rst_ovf", 32'(overflow), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    do_op("max", 32'h0000_0001, 5'd31, 1'b0, 0);
    do_op("zero", 32'hDEAD_BEEF, 5'd0, 1'b0, 0);
    do_op("fill", 32'h8000_0001, 5'd4, 1'b1, 0);
    check("fill_val", result, 32'h0000_001F);
    do_op("busy", 32'h0000_00FF, 5'd8, 1'b0, 1);
    check("busy_val", result, 32'h0000_FF00);
    do_op("allones", 32'h0000_0000, 5'd31, 1'b1, 0);
    check("allones_val", result, 32'h7FFF_FFFF);

    data_in = $urandom;
    shamt   = 5'd20;
    lsb     = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_ready", 32'(ready), 32'd1);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op("post_rst", 32'h0000_0003, 5'd2, 1'b0, 0);
    check("post_rst_val", result, 32'h0000_000C);

    for (int k = 0; k < 40; k++) begin
      rd = $urandom;
      case ($urandom_range(0, 3))
        0: rs = 5'd0;
        1: rs = 5'd31;
        default: rs = 5'($urandom);
      endcase
      do_op("rand", rd, rs, 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
